// File: rtl/oric_ram_bridge.sv
// Bridges the Oric core's byte-wide RAM strobes onto an SDRAM toggle-handshake port.
// One request in flight plus a single-slot skid; sticky overrun/timeout flags.
module oric_ram_bridge #(
  parameter int ACK_TIMEOUT = 64,
  parameter bit SYNC_IN     = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ram_cs_i,
  input  logic        ram_oe_i,
  input  logic        ram_we_i,
  input  logic [15:0] ram_ad_i,
  input  logic [7:0]  ram_d_i,
  output logic [7:0]  ram_q_o,
  output logic        rd_valid_o,
  output logic        port_req_o,
  input  logic        port_ack_i,
  output logic [15:0] port_a_o,
  output logic [1:0]  port_ds_o,
  output logic        port_we_o,
  output logic [15:0] port_d_o,
  input  logic [15:0] port_q_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int IW = 27;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
  } req_t;

  logic [IW-1:0] raw, syn;
  assign raw = {ram_cs_i, ram_oe_i, ram_we_i, ram_ad_i, ram_d_i};

  // The core runs on its own clock, so strobes may need a two-flop synchroniser.
  if (SYNC_IN) begin : g_sync
    logic [IW-1:0] s1_q, s2_q;
    always_ff @(posedge clk_i) begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
    assign syn = s2_q;
  end else begin : g_nosync
    assign syn = raw;
  end

  logic        s_cs, s_oe, s_we;
  logic [15:0] s_ad;
  logic [7:0]  s_d;
  assign {s_cs, s_oe, s_we, s_ad, s_d} = syn;

  logic        rd_lvl, wr_lvl;
  logic        prev_rd_q, prev_wr_q;
  logic [15:0] ad_prev_q;
  logic        trig;
  req_t        trig_req;

  assign rd_lvl = s_cs & s_oe;
  assign wr_lvl = s_cs & s_we;
  assign trig   = (wr_lvl & ~prev_wr_q) | (rd_lvl & ~prev_rd_q) |
                  (rd_lvl & (s_ad != ad_prev_q));

  // A write strobe wins whenever both strobes are up.
  always_comb begin
    trig_req.a  = s_ad;
    trig_req.we = wr_lvl;
    trig_req.ds = wr_lvl ? (s_ad[0] ? 2'b10 : 2'b01) : 2'b11;
    trig_req.d  = {s_d, s_d};
  end

  // History always tracks the synced inputs, which also re-seeds it during reset.
  always_ff @(posedge clk_i) begin
    prev_rd_q <= rd_lvl;
    prev_wr_q <= wr_lvl;
    ad_prev_q <= s_ad;
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_q, req_d;
  req_t          out_q, out_d;
  logic [7:0]    ram_q_q, ram_q_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovr_q, ovr_d;
  logic          to_q, to_d;
  logic          slot_vld_q, slot_vld_d;
  req_t          slot_q, slot_d;
  logic          issue;
  req_t          iss_req;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    req_d      = req_q;
    out_d      = out_q;
    ram_q_d    = ram_q_q;
    rd_valid_d = 1'b0;
    ovr_d      = ovr_q;
    to_d       = to_q;
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    issue      = 1'b0;
    iss_req    = trig_req;

    case (state_q)
      S_IDLE: begin
        if (slot_vld_q) begin
          issue      = 1'b1;
          iss_req    = slot_q;
          slot_vld_d = 1'b0;
        end else if (trig) begin
          issue = 1'b1;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (port_ack_i == req_q) begin
          state_d = S_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abandon the request; req stays toggled so a late ack is simply absorbed.
          to_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!out_q.we) begin
          ram_q_d    = out_q.a[0] ? port_q_i[15:8] : port_q_i[7:0];
          rd_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      out_d   = iss_req;
      req_d   = ~req_q;
      timer_d = '0;
      state_d = S_WAIT;
    end

    // Triggers that cannot issue directly land in the slot; an IDLE drain frees it.
    if (trig && (state_q != S_IDLE || slot_vld_q)) begin
      if (!slot_vld_q || state_q == S_IDLE) begin
        slot_d     = trig_req;
        slot_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
        if (!trig_req.we || !slot_q.we) slot_d = trig_req;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      req_q      <= 1'b0;
      out_q      <= '{a: 16'h0000, ds: 2'b11, we: 1'b0, d: 16'h0000};
      ram_q_q    <= 8'h00;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_q      <= req_d;
      out_q      <= out_d;
      ram_q_q    <= ram_q_d;
      rd_valid_q <= rd_valid_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
    end
  end

  assign ram_q_o    = ram_q_q;
  assign rd_valid_o = rd_valid_q;
  assign port_req_o = req_q;
  assign port_a_o   = out_q.a;
  assign port_ds_o  = out_q.ds;
  assign port_we_o  = out_q.we;
  assign port_d_o   = out_q.d;
  assign busy_o     = (state_q != S_IDLE) | slot_vld_q;
  assign overrun_o  = ovr_q;
  assign timeout_o  = to_q;

endmodule

// File: tb/tb_oric_ram_bridge.sv
// Self-checking bench: an SDRAM ack model plus a request/read-byte monitor, with
// expectations computed from the bridge's documented transaction rules.
module tb_oric_ram_bridge;
  localparam int TO = 64;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cs = 1'b0, oe = 1'b0, we = 1'b0, ack = 1'b0;
  logic [15:0] ad = 16'h0, pq = 16'h0;
  logic [7:0]  d = 8'h0;
  logic [7:0]  ram_q;
  logic        rd_valid, port_req, port_we, busy, overrun, timeout;
  logic [15:0] port_a, port_d;
  logic [1:0]  port_ds;

  oric_ram_bridge #(.ACK_TIMEOUT(TO), .SYNC_IN(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .ram_cs_i(cs), .ram_oe_i(oe), .ram_we_i(we),
    .ram_ad_i(ad), .ram_d_i(d), .ram_q_o(ram_q), .rd_valid_o(rd_valid),
    .port_req_o(port_req), .port_ack_i(ack), .port_a_o(port_a), .port_ds_o(port_ds),
    .port_we_o(port_we), .port_d_o(port_d), .port_q_i(pq), .busy_o(busy),
    .overrun_o(overrun), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ack_dly = 5, ack_cnt = 0;
  bit ack_en = 1'b1;

  typedef struct { logic [15:0] a; logic [1:0] ds; logic we; logic [15:0] d; } req_t;
  req_t       iss[$];
  logic [7:0] rdq[$];
  logic       prev_req = 1'b0;

  // SDRAM port model and transaction monitor
  always @(negedge clk) begin
    if (reset) begin
      ack = 1'b0; ack_cnt = 0; prev_req = 1'b0;
      iss.delete(); rdq.delete();
    end else begin
      if (port_req !== prev_req) begin
        iss.push_back('{port_a, port_ds, port_we, port_d});
        prev_req = port_req;
      end
      if (rd_valid) rdq.push_back(ram_q);
      if (ack_en && port_req !== ack) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin ack = port_req; ack_cnt = 0; end
      end
    end
  end

  function automatic logic [1:0] exp_ds(input logic w, input logic [15:0] a);
    return w ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [15:0] a, input logic [15:0] q);
    return a[0] ? q[15:8] : q[7:0];
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((n < 4 || busy || port_req !== ack) && n < 400);
    repeat (2) @(negedge clk);
    checks++;
    if (busy || port_req !== ack) begin
      errors++; $display("FAIL %s idle_wait: busy=%b req=%b ack=%b after %0d cycles", nm, busy, port_req, ack, n);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({port_req, port_a, port_ds, port_we, port_d, ram_q, rd_valid, busy, overrun, timeout} !==
        {1'b0, 16'h0, 2'b11, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s reset_vals: req=%b a=%h ds=%b we=%b d=%h q=%h rv=%b busy=%b ovr=%b to=%b, want 0/0/11/0/0/0/0/0/0/0",
               nm, port_req, port_a, port_ds, port_we, port_d, ram_q, rd_valid, busy, overrun, timeout);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
  endtask

  task automatic test_read();
    int lat = 0, n0, r0;
    logic r_before;
    n0 = iss.size(); r0 = rdq.size();
    pq = 16'hAB12; ack_dly = 5;
    r_before = port_req;
    @(negedge clk); ad = 16'h1235; cs = 1'b1; oe = 1'b1;
    do begin @(negedge clk); lat++; end while (port_req === r_before && lat < 12);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d cycles, want 3", lat); end
    wait_idle("read");
    checks++;
    if (iss.size() != n0 + 1) begin
      errors++; $display("FAIL read_issue_count: got %0d, want %0d", iss.size() - n0, 1);
    end else if (iss[n0].a !== 16'h1235 || iss[n0].ds !== 2'b11 || iss[n0].we !== 1'b0) begin
      errors++; $display("FAIL read_request: a=%h ds=%b we=%b, want 1235/11/0", iss[n0].a, iss[n0].ds, iss[n0].we);
    end
    checks++;
    if (rdq.size() != r0 + 1 || rdq[rdq.size()-1] !== 8'hAB) begin
      errors++; $display("FAIL read_data: pulses=%0d q=%h, want 1 pulse q=ab", rdq.size() - r0, ram_q);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b, want 0", busy); end
    cs = 1'b0; oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    int n0, r0;
    logic [15:0] a;
    logic [7:0]  dv;
    for (int i = 0; i < 8; i++) begin
      a  = (i == 0) ? 16'h0400 : 16'($urandom);
      dv = (i == 0) ? 8'h5A : 8'($urandom);
      n0 = iss.size(); r0 = rdq.size();
      @(negedge clk); ad = a; d = dv; cs = 1'b1; we = 1'b1;
      wait_idle("write");
      checks++;
      if (iss.size() != n0 + 1) begin
        errors++; $display("FAIL write_issue_count[%0d]: got %0d, want 1", i, iss.size() - n0);
      end else if (iss[n0].a !== a || iss[n0].we !== 1'b1 || iss[n0].ds !== exp_ds(1'b1, a) ||
                   iss[n0].d !== {dv, dv}) begin
        errors++;
        $display("FAIL write_request[%0d]: a=%h we=%b ds=%b d=%h, want %h/1/%b/%h",
                 i, iss[n0].a, iss[n0].we, iss[n0].ds, iss[n0].d, a, exp_ds(1'b1, a), {dv, dv});
      end
      checks++;
      if (rdq.size() != r0) begin errors++; $display("FAIL write_no_rdvalid[%0d]: got %0d pulses, want 0", i, rdq.size() - r0); end
      we = 1'b0; cs = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_addr_change();
    int n0, r0;
    logic [15:0] a;
    n0 = iss.size(); r0 = rdq.size();
    pq = 16'hC35E;
    @(negedge clk); ad = 16'h2000; cs = 1'b1; oe = 1'b1;
    wait_idle("addr0");
    ad = 16'h2001;
    wait_idle("addr1");
    checks++;
    if (iss.size() != n0 + 2 || rdq.size() != r0 + 2) begin
      errors++; $display("FAIL addr_change_count: issues=%0d reads=%0d, want 2/2", iss.size() - n0, rdq.size() - r0);
    end else if (iss[n0+1].a !== 16'h2001 || rdq[r0] !== 8'h5E || rdq[r0+1] !== 8'hC3) begin
      errors++; $display("FAIL addr_change_data: a=%h q0=%h q1=%h, want 2001/5e/c3", iss[n0+1].a, rdq[r0], rdq[r0+1]);
    end
    for (int i = 0; i < 6; i++) begin
      a = ad ^ 16'(1 + $urandom_range(0, 16'hFFFE));
      pq = 16'($urandom);
      n0 = iss.size(); r0 = rdq.size();
      ad = a;
      wait_idle("addr_rand");
      checks++;
      if (iss.size() != n0 + 1 || rdq.size() != r0 + 1) begin
        errors++; $display("FAIL addr_rand_count[%0d]: issues=%0d reads=%0d, want 1/1", i, iss.size() - n0, rdq.size() - r0);
      end else if (iss[n0].a !== a || iss[n0].ds !== 2'b11 || rdq[r0] !== exp_byte(a, pq)) begin
        errors++; $display("FAIL addr_rand_data[%0d]: a=%h ds=%b q=%h, want %h/11/%h", i, iss[n0].a, iss[n0].ds, rdq[r0], a, exp_byte(a, pq));
      end
    end
    cs = 1'b0; oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n0, r0;
    n0 = iss.size(); r0 = rdq.size();
    pq = 16'h6B2C; ack_dly = 20;
    @(negedge clk); ad = 16'h3000; cs = 1'b1; oe = 1'b1;
    repeat (6) @(negedge clk); ad = 16'h3002;
    repeat (4) @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first_queued: got %b, want 0", overrun); end
    ad = 16'h3003;
    wait_idle("overrun");
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, want 1", overrun); end
    checks++;
    if (iss.size() != n0 + 2 || rdq.size() != r0 + 2) begin
      errors++; $display("FAIL overrun_count: issues=%0d reads=%0d, want 2/2", iss.size() - n0, rdq.size() - r0);
    end else if (iss[n0].a !== 16'h3000 || iss[n0+1].a !== 16'h3003 || rdq[r0+1] !== 8'h6B) begin
      errors++; $display("FAIL overrun_order: a0=%h a1=%h q=%h, want 3000/3003/6b", iss[n0].a, iss[n0+1].a, rdq[r0+1]);
    end
    cs = 1'b0; oe = 1'b0;
    // write-over-write in the slot is discarded
    reset_dut();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b, want 0", overrun); end
    n0 = iss.size(); r0 = rdq.size(); ack_dly = 30;
    @(negedge clk); ad = 16'h4000; cs = 1'b1; oe = 1'b1;
    repeat (6) @(negedge clk); d = 8'h11; we = 1'b1;
    repeat (3) @(negedge clk); we = 1'b0;
    repeat (3) @(negedge clk); d = 8'h22; we = 1'b1;
    wait_idle("wr_discard");
    checks++;
    if (iss.size() != n0 + 2 || overrun !== 1'b1) begin
      errors++; $display("FAIL wr_discard_count: issues=%0d ovr=%b, want 2/1", iss.size() - n0, overrun);
    end else if (iss[n0+1].we !== 1'b1 || iss[n0+1].d !== 16'h1111 || iss[n0+1].ds !== 2'b01) begin
      errors++; $display("FAIL wr_discard_kept: we=%b d=%h ds=%b, want 1/1111/01", iss[n0+1].we, iss[n0+1].d, iss[n0+1].ds);
    end
    we = 1'b0; cs = 1'b0; oe = 1'b0; ack_dly = 5;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n0, r0, n = 0;
    logic r_before;
    n0 = iss.size(); r0 = rdq.size();
    ack_en = 1'b0; pq = 16'h9A7C;
    r_before = port_req;
    @(negedge clk); ad = 16'h5001; cs = 1'b1; oe = 1'b1;
    do begin @(negedge clk); n++; end while (port_req === r_before && n < 12);
    checks++;
    if (port_req === r_before) begin errors++; $display("FAIL timeout_issue: no req toggle within %0d cycles", n); end
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b at %0d cycles, want 0", timeout, TO - 1); end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_set: to=%b busy=%b at %0d cycles, want 1/0", timeout, busy, TO);
    end
    ack_en = 1'b1;                       // late ack arrives while idle
    repeat (10) @(negedge clk);
    checks++;
    if (rdq.size() != r0 || iss.size() != n0 + 1) begin
      errors++; $display("FAIL timeout_late_ack: reads=%0d issues=%0d, want 0/1", rdq.size() - r0, iss.size() - n0);
    end
    oe = 1'b0;
    repeat (3) @(negedge clk); ad = 16'h5003; oe = 1'b1;
    wait_idle("after_timeout");
    checks++;
    if (iss.size() != n0 + 2 || rdq.size() != r0 + 1 || ram_q !== 8'h9A || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_recover: issues=%0d reads=%0d q=%h to=%b, want 2/1/9a/1",
                         iss.size() - n0, rdq.size() - r0, ram_q, timeout);
    end
    cs = 1'b0; oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    ack_en = 1'b0;
    @(negedge clk); ad = 16'h6000; cs = 1'b1; oe = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b, want 1", busy); end
    reset_dut();
    ack_en = 1'b1;
    repeat (8) @(negedge clk);
    check_reset_vals("reset_in_wait");
    checks++;
    if (iss.size() != 0) begin errors++; $display("FAIL rst_wait_spurious: got %0d requests, want 0", iss.size()); end
    cs = 1'b0; oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_addr_change();
    test_overrun();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
